wb_traffic_gen: RTL

//  Synthesizable Wishbone master that drives the sdrc_top Wishbone slave port from the upstream side.

---
 rtl/wb_traffic_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_traffic_gen.sv
// rtl/wb_traffic_gen.sv - Wishbone burst write/read-back traffic generator with self-check
module wb_traffic_gen #(
  parameter int              DW         = 32,
  parameter int              AW         = 32,
  parameter int              BURST_LEN  = 8,
  parameter int              NUM_BURSTS = 4,
  parameter logic [AW-1:0]   BASE_ADDR  = '0,
  parameter logic [31:0]     SEED       = 32'hACE10001,
  parameter int              TIMEOUT    = 1024
) (
  input  logic              sys_clk,
  input  logic              RESETN,
  input  logic              sdr_init_done,
  input  logic              start,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [AW-1:0]     first_err_addr
);

  localparam int TOTAL = BURST_LEN * NUM_BURSTS;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_INIT, S_WR, S_GAP, S_RD, S_FIN} state_t;

  state_t        state;
  logic          init_seen;
  logic          rd_phase;
  logic [31:0]   widx;
  logic [5:0]    beat;
  logic [TW-1:0] to_cnt;

  function automatic logic [DW-1:0] pat(input logic [31:0] n);
    logic [31:0] p;
    p = (n * 32'h9E3779B9) ^ SEED;
    return DW'(p);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [31:0] n);
    return BASE_ADDR + AW'(n) * AW'(DW / 8);
  endfunction

  function automatic logic [2:0] cti_of(input logic [5:0] b);
    return (b == 6'(BURST_LEN - 1)) ? 3'b111 : 3'b010;
  endfunction

  // Word index after the current beat, and where the next burst starts from a gap
  logic [31:0] widx_inc;
  logic        beat_last;
  logic        to_rd;
  logic        rd_next;
  logic [31:0] gap_n;
  logic        mismatch;
  logic [15:0] err_next;

  assign widx_inc  = widx + 32'd1;
  assign beat_last = (beat == 6'(BURST_LEN - 1));
  assign to_rd     = !rd_phase && (widx == 32'(TOTAL));
  assign rd_next   = rd_phase | to_rd;
  assign gap_n     = to_rd ? 32'd0 : widx;
  assign mismatch  = (state == S_RD) && wb_ack_i && (wb_dat_i != pat(widx));
  assign err_next  = (mismatch && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;

  // Pass sequencer: every bus and status output is registered here
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state          <= S_IDLE;
      init_seen      <= 1'b0;
      rd_phase       <= 1'b0;
      widx           <= '0;
      beat           <= '0;
      to_cnt         <= '0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_sel_o       <= '0;
      wb_dat_o       <= '0;
      wb_cti_o       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            busy           <= 1'b1;
            init_seen      <= 1'b0;
            rd_phase       <= 1'b0;
            widx           <= '0;
            state          <= S_WAIT_INIT;
          end
        end

        // Both present the first beat of a burst; WAIT_INIT only once init has been seen
        S_WAIT_INIT, S_GAP: begin
          if (state == S_GAP || init_seen) begin
            to_cnt    <= '0;
            beat      <= '0;
            widx      <= gap_n;
            rd_phase  <= rd_next;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= !rd_next;
            wb_sel_o  <= '1;
            wb_addr_o <= addr_of(gap_n);
            wb_dat_o  <= rd_next ? '0 : pat(gap_n);
            wb_cti_o  <= cti_of(6'd0);
            state     <= rd_next ? S_RD : S_WR;
          end else if (sdr_init_done) begin
            init_seen <= 1'b1;
          end
        end

        S_WR, S_RD: begin
          if (wb_ack_i) begin
            to_cnt <= '0;
            widx   <= widx_inc;
            if (state == S_RD) begin
              err_cnt <= err_next;
              if (mismatch && err_cnt == 16'd0) first_err_addr <= wb_addr_o;
            end
            if (beat_last) begin
              wb_cyc_o  <= 1'b0;
              wb_stb_o  <= 1'b0;
              wb_we_o   <= 1'b0;
              wb_sel_o  <= '0;
              wb_cti_o  <= '0;
              wb_addr_o <= '0;
              wb_dat_o  <= '0;
              if (state == S_RD && widx_inc == 32'(TOTAL)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == 16'd0);
                state <= S_FIN;
              end else begin
                state <= S_GAP;
              end
            end else begin
              beat      <= beat + 6'd1;
              wb_addr_o <= addr_of(widx_inc);
              wb_dat_o  <= (state == S_WR) ? pat(widx_inc) : '0;
              wb_cti_o  <= cti_of(beat + 6'd1);
            end
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            // Slave stalled too long: abandon the pass and report it
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_cti_o  <= '0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            timeout   <= 1'b1;
            done      <= 1'b1;
            pass      <= 1'b0;
            busy      <= 1'b0;
            state     <= S_FIN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // Results stay visible in IDLE; dropping to IDLE only on start low forces a fresh edge
        S_FIN: begin
          if (!start) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
